fp_sum_master: RTL and testbench

//  Initiator side of the stb/ack float handshake. Streams N single-precision words from an upstream producer

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_sum_master_stb_ack_tx.sv | 28 ++
 rtl/fp_sum_master.sv | 141 ++++++++++++++
 tb/tb_fp_sum_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision sum reducer.
package fp_pkg;

    typedef enum logic [2:0] {
        GET_X   = 3'd0,
        SEND_A  = 3'd1,
        SEND_B  = 3'd2,
        GET_Z   = 3'd3,
        PUT_SUM = 3'd4
    } state_t;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN_NEG = 32'hFFC0_0000;

    // True for +0 and -0; the sign bit is ignored.
    function automatic logic fp_is_zero(input logic [31:0] v);
        return v[30:0] == 31'd0;
    endfunction

endpackage

// File: rtl/fp_sum_master_stb_ack_tx.sv
// One-slot stb/ack transmitter: load captures data and raises stb, a transfer drops stb.
module stb_ack_tx #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         stb,
    input  logic         ack
);

    // NOTE: state uses non-blocking assignments under an async active-low reset so every
    // register samples pre-edge values and clears immediately when rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            stb  <= 1'b0;
        end else if (load) begin
            data <= load_data;
            stb  <= 1'b1;
        end else if (stb && ack) begin
            stb  <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_sum_master.sv
// Softmax-denominator reducer: streams N floats through an external adder and offers the sum.
// Optional FP_SUM_SKIP_ZERO_EN: +/-0 elements are counted without an adder transaction.
module fp_sum_master
    import fp_pkg::*;
#(
    parameter int N = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] add_a,
    output logic        add_a_stb,
    input  logic        add_a_ack,
    output logic [31:0] add_b,
    output logic        add_b_stb,
    input  logic        add_b_ack,
    input  logic [31:0] add_z,
    input  logic        add_z_stb,
    output logic        add_z_ack,
    output logic [31:0] sum,
    output logic        sum_stb,
    input  logic        sum_ack
);

    localparam int              CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state, state_nxt;
    logic [31:0]      x, x_nxt, acc, acc_nxt, sum_load;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             in_ack_nxt, z_ack_nxt;
    logic             load_a, load_b, load_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= GET_X;
            x         <= FP_POS_ZERO;
            acc       <= FP_POS_ZERO;
            cnt       <= '0;
            in_ack    <= 1'b0;
            add_z_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            in_ack    <= in_ack_nxt;
            add_z_ack <= z_ack_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        x_nxt      = x;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        in_ack_nxt = 1'b0;
        z_ack_nxt  = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_sum   = 1'b0;
        sum_load   = add_z;
        case (state)
            GET_X: begin
                in_ack_nxt = 1'b1;
                if (in_stb && in_ack) begin
                    in_ack_nxt = 1'b0;
`ifdef FP_SUM_SKIP_ZERO_EN
                    if (fp_is_zero(in_data)) begin
                        // acc is never -0, so adding a zero would leave it unchanged anyway.
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == LAST) begin
                            sum_load  = acc;
                            load_sum  = 1'b1;
                            state_nxt = PUT_SUM;
                        end
                    end else begin
                        x_nxt     = in_data;
                        load_a    = 1'b1;
                        state_nxt = SEND_A;
                    end
`else
                    x_nxt     = in_data;
                    load_a    = 1'b1;
                    state_nxt = SEND_A;
`endif
                end
            end
            SEND_A: begin
                if (add_a_stb && add_a_ack) begin
                    load_b    = 1'b1;
                    state_nxt = SEND_B;
                end
            end
            SEND_B: begin
                if (add_b_stb && add_b_ack) state_nxt = GET_Z;
            end
            GET_Z: begin
                z_ack_nxt = 1'b1;
                if (add_z_stb && add_z_ack) begin
                    z_ack_nxt = 1'b0;
                    acc_nxt   = add_z;
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == LAST) begin
                        load_sum  = 1'b1;
                        state_nxt = PUT_SUM;
                    end else begin
                        state_nxt = GET_X;
                    end
                end
            end
            PUT_SUM: begin
                if (sum_stb && sum_ack) begin
                    acc_nxt   = FP_POS_ZERO;
                    cnt_nxt   = '0;
                    state_nxt = GET_X;
                end
            end
            default: state_nxt = GET_X;
        endcase
    end

    stb_ack_tx #(.W(32)) u_tx_a (
        .clk(clk), .rst(rst), .load(load_a), .load_data(acc),
        .data(add_a), .stb(add_a_stb), .ack(add_a_ack)
    );

    stb_ack_tx #(.W(32)) u_tx_b (
        .clk(clk), .rst(rst), .load(load_b), .load_data(x),
        .data(add_b), .stb(add_b_stb), .ack(add_b_ack)
    );

    stb_ack_tx #(.W(32)) u_tx_sum (
        .clk(clk), .rst(rst), .load(load_sum), .load_data(sum_load),
        .data(sum), .stb(sum_stb), .ack(sum_ack)
    );

endmodule

// File: tb/tb_fp_sum_master.sv
// Bench for fp_sum_master: an N=4 and an N=1 instance, each with producer, adder and consumer models.
module tb_fp_sum_master;
    import fp_pkg::*;

    localparam int LANES = 2;
`ifdef FP_SUM_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] in_data [LANES];
    logic [31:0] add_z   [LANES];
    logic        in_stb    [LANES];
    logic        add_a_ack [LANES];
    logic        add_b_ack [LANES];
    logic        add_z_stb [LANES];
    logic        sum_ack   [LANES];

    wire [LANES-1:0] in_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb;
    wire [31:0]      add_a [LANES];
    wire [31:0]      add_b [LANES];
    wire [31:0]      sum   [LANES];

    fp_sum_master #(.N(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data[0]), .in_stb(in_stb[0]), .in_ack(in_ack[0]),
        .add_a(add_a[0]), .add_a_stb(add_a_stb[0]), .add_a_ack(add_a_ack[0]),
        .add_b(add_b[0]), .add_b_stb(add_b_stb[0]), .add_b_ack(add_b_ack[0]),
        .add_z(add_z[0]), .add_z_stb(add_z_stb[0]), .add_z_ack(add_z_ack[0]),
        .sum(sum[0]), .sum_stb(sum_stb[0]), .sum_ack(sum_ack[0])
    );

    fp_sum_master #(.N(1)) u_dut_n1 (
        .clk(clk), .rst(rst),
        .in_data(in_data[1]), .in_stb(in_stb[1]), .in_ack(in_ack[1]),
        .add_a(add_a[1]), .add_a_stb(add_a_stb[1]), .add_a_ack(add_a_ack[1]),
        .add_b(add_b[1]), .add_b_stb(add_b_stb[1]), .add_b_ack(add_b_ack[1]),
        .add_z(add_z[1]), .add_z_stb(add_z_stb[1]), .add_z_ack(add_z_ack[1]),
        .sum(sum[1]), .sum_stb(sum_stb[1]), .sum_ack(sum_ack[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Adder reference: specials by hand, finite values through double precision (exact here).
    function automatic real s2r(input logic [31:0] v);
        if (v[30:0] == 31'd0) return $bitstoreal({v[31], 63'd0});
        return $bitstoreal({v[31], {3'b000, v[30:23]} + 11'd896, v[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        bits = $realtobits(r);
        if (bits[62:0] == 63'd0) return {bits[63], 31'd0};
        e = bits[62:52] - 11'd896;
        return {bits[63], e[7:0], bits[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return FP_QNAN_NEG;
        if (a_inf) return a;
        if (b_inf) return b;
        return r2s(s2r(a) + s2r(b));
    endfunction

    // Bus models: observe at negedge (values held until the next posedge), drive at posedge+1.
    logic [31:0] feed    [LANES][$];
    logic [31:0] got_sum [LANES][$];
    logic        hold_sum [LANES];
    int          a_xf [LANES], b_xf [LANES], z_xf [LANES], s_xf [LANES];
    int          ast  [LANES];
    logic [31:0] opa  [LANES], cap_a [LANES], cap_b [LANES], cap_s [LANES];
    logic        xin [LANES], xa [LANES], xb [LANES], xz [LANES], xs [LANES];

    initial begin
        logic [31:0] dummy;
        for (int l = 0; l < LANES; l++) begin
            in_data[l] = '0; in_stb[l] = 1'b0; add_z[l] = '0;
            add_a_ack[l] = 1'b0; add_b_ack[l] = 1'b0; add_z_stb[l] = 1'b0; sum_ack[l] = 1'b0;
            hold_sum[l] = 1'b0; ast[l] = 0; opa[l] = '0;
            a_xf[l] = 0; b_xf[l] = 0; z_xf[l] = 0; s_xf[l] = 0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < LANES; l++) begin
                xin[l]   = in_stb[l] && in_ack[l];
                xa[l]    = add_a_stb[l] && add_a_ack[l];
                xb[l]    = add_b_stb[l] && add_b_ack[l];
                xz[l]    = add_z_stb[l] && add_z_ack[l];
                xs[l]    = sum_stb[l] && sum_ack[l];
                cap_a[l] = add_a[l];
                cap_b[l] = add_b[l];
                cap_s[l] = sum[l];
            end
            @(posedge clk);
            #1;
            for (int l = 0; l < LANES; l++) begin
                if (!rst) begin
                    in_stb[l] = 1'b0; add_a_ack[l] = 1'b0; add_b_ack[l] = 1'b0;
                    add_z_stb[l] = 1'b0; sum_ack[l] = 1'b0; ast[l] = 0;
                end else begin
                    if (xin[l] && feed[l].size() > 0) dummy = feed[l].pop_front();
                    if (feed[l].size() > 0) begin
                        in_data[l] = feed[l][0];
                        in_stb[l]  = 1'b1;
                    end else begin
                        in_stb[l]  = 1'b0;
                    end
                    case (ast[l])
                        0: if (xa[l]) begin
                               a_xf[l]++; opa[l] = cap_a[l]; add_a_ack[l] = 1'b0; ast[l] = 1;
                           end else add_a_ack[l] = 1'b1;
                        1: if (xb[l]) begin
                               b_xf[l]++; add_b_ack[l] = 1'b0;
                               add_z[l] = fadd(opa[l], cap_b[l]); add_z_stb[l] = 1'b1; ast[l] = 2;
                           end else add_b_ack[l] = 1'b1;
                        default: if (xz[l]) begin
                               z_xf[l]++; add_z_stb[l] = 1'b0; ast[l] = 0;
                           end
                    endcase
                    if (xs[l]) begin
                        s_xf[l]++;
                        got_sum[l].push_back(cap_s[l]);
                        sum_ack[l] = 1'b0;
                    end else begin
                        sum_ack[l] = !hold_sum[l];
                    end
                end
            end
        end
    end

    task automatic push4(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3);
        feed[0].push_back(v0); feed[0].push_back(v1);
        feed[0].push_back(v2); feed[0].push_back(v3);
    endtask

    task automatic wait_sum(input int l, input logic [31:0] exp, input string tag);
        logic [31:0] got;
        int cyc;
        got = 'x;
        cyc = 0;
        while (got_sum[l].size() == 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (got_sum[l].size() != 0) got = got_sum[l].pop_front();
        else $display("timeout waiting for %s", tag);
        check(tag, got, exp);
    endtask

    initial begin
        int base_a, base_b, base_z, base_s, stable, cyc;

        repeat (3) @(negedge clk);
        check("rst_ctrl", {22'd0, in_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb}, 32'd0);
        check("rst_sum", sum[0], FP_POS_ZERO);
        check("rst_add_a", add_a[0], FP_POS_ZERO);
        check("rst_add_b", add_b[0], FP_POS_ZERO);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ack_rise", {30'd0, in_ack}, 32'd3);

        // Four ones.
        base_a = a_xf[0]; base_b = b_xf[0]; base_z = z_xf[0]; base_s = s_xf[0];
        push4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        wait_sum(0, 32'h4080_0000, "sum_ones");
        repeat (20) @(negedge clk);
        check("ones_sum_xfers", 32'(s_xf[0] - base_s), 32'd1);
        check("ones_a_xfers", 32'(a_xf[0] - base_a), 32'd4);
        check("ones_b_xfers", 32'(b_xf[0] - base_b), 32'd4);
        check("ones_z_xfers", 32'(z_xf[0] - base_z), 32'd4);

        // 1.5 + 2.5 - 4.0 + 0 cancels to +0.
        base_a = a_xf[0];
        push4(32'h3FC0_0000, 32'h4020_0000, 32'hC080_0000, 32'h0000_0000);
        wait_sum(0, 32'h0000_0000, "sum_cancel");
        check("cancel_a_xfers", 32'(a_xf[0] - base_a), SKIP ? 32'd3 : 32'd4);

        // inf + -inf gives NaN, which then sticks.
        push4(32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h3F80_0000);
        wait_sum(0, FP_QNAN_NEG, "sum_nan");

        // Zeros of both signs among ones.
        base_a = a_xf[0];
        push4(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h8000_0000);
        wait_sum(0, 32'h4000_0000, "sum_zeros");
        check("zeros_a_xfers", 32'(a_xf[0] - base_a), SKIP ? 32'd2 : 32'd4);

        // N=1 lane: one addition 0 + x0.
        feed[1].push_back(32'h7F80_0000);
        wait_sum(1, 32'h7F80_0000, "n1_inf");
        base_a = a_xf[1];
        feed[1].push_back(32'h8000_0000);
        wait_sum(1, 32'h0000_0000, "n1_negzero");
        check("n1_negzero_a_xfers", 32'(a_xf[1] - base_a), SKIP ? 32'd0 : 32'd1);

        // Backpressure on the sum port with the next batch already waiting.
        hold_sum[0] = 1'b1;
        push4(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        push4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        cyc = 0;
        while (!sum_stb[0] && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sum_stb[0] && sum[0] == 32'h4100_0000 && !in_ack[0] && in_stb[0]) stable++;
        end
        check("bp_hold_cycles", 32'(stable), 32'd50);
        hold_sum[0] = 1'b0;
        wait_sum(0, 32'h4100_0000, "bp_sum");
        wait_sum(0, 32'h4080_0000, "bp_next_batch");

        // Reset while the N=4 lane sits in SEND_B.
        feed[0].push_back(32'h3F80_0000);
        cyc = 0;
        while (!(add_b_stb[0] && !add_b_ack[0]) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_send_b", {31'd0, add_b_stb[0]}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ctrl", {22'd0, in_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb}, 32'd0);
        check("mid_rst_add_b", add_b[0], FP_POS_ZERO);
        feed[0].delete();
        feed[1].delete();
        got_sum[0].delete();
        got_sum[1].delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        feed[1].push_back(32'h4000_0000);
        wait_sum(1, 32'h4000_0000, "n1_after_rst");
        push4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        wait_sum(0, 32'h4080_0000, "n4_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
